uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised successor to the single-byte debug UART receiver. It keeps the fractional baud accumulator and 16x oversampling, and adds:
- configurable data width and parity mode
- false-start rejection
- framing and parity error detection
- a first-word-fall-through receive FIFO with a valid/ready output
It sits between an FTDI/GPIO rx pin and any consumer, such as the LED display or a command decoder.

Parameters:
BAUD_ACC_WIDTH, 14, accumulator width. Tick rate = f_clk * BAUD_ACC_INCR / 2^BAUD_ACC_WIDTH, which must equal 16x baud.
BAUD_ACC_INCR, 101, accumulator increment. Must be <= 2^BAUD_ACC_WIDTH.
DATA_BITS, 8, data bits per frame, range 5..9, sent LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
FIFO_DEPTH, 4, entry count, power of 2, >= 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_rx  in  1  asynchronous serial line, idles high
o_data  out  DATA_BITS  FIFO head byte
o_valid  out  1  FIFO non-empty
i_ready  in  1  consumer pops the head when o_valid && i_ready
o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_frame_err  out  1  sticky: a stop bit was sampled low
o_parity_err  out  1  sticky: parity mismatch
o_overflow  out  1  sticky: a good byte arrived while the FIFO was full
i_clear_err  in  1  clears all three sticky flags

Behaviour:
Reset values:
- Outputs: o_valid=0, o_count=0, o_data=0, all error flags 0.
- Internal: accumulator 0, synchroniser flops 1, FSM in IDLE, FIFO pointers 0.

Input sync:
- 2-flop synchroniser on i_rx.
- All references to "rx" below mean the synchronised value.

Baud generator:
- Accumulator is BAUD_ACC_WIDTH+1 bits; each cycle it becomes {0, acc[W-1:0]} + INCR.
- tick = acc[W], i.e. the carry out.
- It runs continuously and is never restarted by the FSM.

Oversample counter:
- 4 bits, advances only on a tick.
- Cleared when a start edge is detected.
- The mid-bit sample point is the tick at which the counter = 7.

FSM states and transitions:
- IDLE: a tick with rx=0 clears the counter and goes to START.
- START: at counter=7, if rx=1 this is a false start → IDLE with nothing logged; otherwise clear the counter → DATA.
- DATA: sample at counter=7 of each bit, shifting into the MSB so the first bit lands in bit 0. After DATA_BITS samples go to PARITY (if PARITY!=0), else to STOP.
- PARITY: sample at counter=7. Mismatch sets a pending parity error. Even parity means the XOR of data and parity bit is 0.
- STOP: sample at counter=7.
  - rx=0: set o_frame_err, discard the byte → BREAK.
  - rx=1 with a pending parity error: set o_parity_err, discard the byte → IDLE.
  - rx=1 otherwise: push the byte → IDLE.
- BREAK: wait for a tick with rx=1 → IDLE. This stops a held-low line from re-triggering the receiver.

Timing and FIFO rules:
- Push latency: o_valid rises one clock after the stop-sample tick cycle.
- o_data is registered from the FIFO head and is valid whenever o_valid=1.
- Push while full with no pop: the byte is dropped, o_overflow is set, FIFO contents are unchanged.
- Push while full with a pop in the same cycle: both succeed, o_count is unchanged.
- Push and pop on a non-full, non-empty FIFO: both succeed, o_count is unchanged.
- Push while empty: i_ready has no effect that cycle.
- Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.
- i_clear_err in the same cycle as a new error: the flag stays set (set wins).
- i_rst mid-frame: the frame is abandoned, the FIFO is emptied and flags are cleared. The next falling edge after release starts a fresh frame.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
  - OS_MID=7 and OS_LAST=15 constants
- Sub-module sync_fifo, parameters WIDTH and DEPTH:
  - ports i_clk, i_rst, push/data in, pop, head, count, full, empty
  - implements the push/pop rules above
- Baud accumulator and FSM stay inline.

Test Plan:
Bench parameters: BAUD_ACC_WIDTH=4, BAUD_ACC_INCR=16, giving a tick every clock and 16 clocks per bit.
1. Basic frame: send 0xA5 with 8N1 and i_ready=0. Expect o_valid=1 with o_data=0xA5 one clock after the stop sample, o_count=1, all flags 0. Then pulse i_ready for 1 clock: expect o_valid=0, o_count=0.
2. Even parity: PARITY=1, send 0x03 with parity bit 0 → accepted. Send 0x03 with parity bit 1 → o_parity_err=1, o_count unchanged. Pulse i_clear_err → o_parity_err=0.
3. Framing error and break: send 0x55 with the stop bit low, then hold rx low for 40 bit times → exactly one o_frame_err set, no push, no further frames. Release rx high, send 0x12 → received correctly.
4. False start: drive a rx low glitch of 4 clocks → FSM returns to IDLE, o_count=0, no flags set.
5. Overflow: FIFO_DEPTH=4, i_ready=0, send 0x01..0x05 → o_count=4, o_overflow=1. Pop four entries → reads 0x01, 0x02, 0x03, 0x04.
6. Full with simultaneous pop: with the FIFO full, hold i_ready=1 exactly on the push cycle → o_overflow stays 0, o_count stays 4, new byte sits at the tail. Also assert i_rst mid-frame → all outputs return to reset values within 1 clock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and parity helper for the oversampling UART receiver.

package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam logic [3:0] OS_MID  = 4'd7;
   localparam logic [3:0] OS_LAST = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   // Returns 1 when the received parity bit disagrees with the data XOR for the given mode.
   function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                       input int unsigned mode);
      logic bad;
      bad = 1'b0;
      if (mode == PARITY_EVEN) begin
         bad = data_xor ^ par_bit;
      end else if (mode == PARITY_ODD) begin
         bad = ~(data_xor ^ par_bit);
      end
      return bad;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and occupancy count.

module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_next;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
   assign push_ok = push && (!full || pop_ok);
   assign rd_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_next;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // The word being written this cycle bypasses the array when it becomes the head.
         if (push_ok && (rd_next == wr_ptr)) begin
            head <= din;
         end else begin
            head <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver with fractional baud accumulator, parity/framing
// checks, false-start rejection and a valid/ready receive FIFO.

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int unsigned BAUD_ACC_WIDTH = 14,
   parameter  int unsigned BAUD_ACC_INCR  = 101,
   parameter  int unsigned DATA_BITS      = 8,
   parameter  int unsigned PARITY         = 0,
   parameter  int unsigned FIFO_DEPTH     = 4,
   localparam int unsigned CW             = $clog2(FIFO_DEPTH) + 1,
   localparam int unsigned ACC_W          = BAUD_ACC_WIDTH + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [CW-1:0]        o_count,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overflow,
   input  logic                 i_clear_err
);

   logic                 rx_meta;
   logic                 rx_sync;
   logic [ACC_W-1:0]     acc;
   logic                 tick;
   state_t               state;
   logic [3:0]           os_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 par_pend;

   logic                 mid_c;
   logic                 stop_mid_c;
   logic                 push_c;
   logic                 frame_set_c;
   logic                 parity_set_c;
   logic                 overflow_set_c;
   logic                 fifo_full;
   logic                 fifo_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // Free-running fractional accumulator; its carry out is the 16x oversample tick.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc <= '0;
      end else begin
         acc <= {1'b0, acc[BAUD_ACC_WIDTH-1:0]} + ACC_W'(BAUD_ACC_INCR);
      end
   end

   assign tick = acc[BAUD_ACC_WIDTH];

   assign mid_c          = tick && (os_cnt == OS_MID);
   assign stop_mid_c     = (state == ST_STOP) && mid_c;
   assign push_c         = stop_mid_c && rx_sync && !par_pend;
   assign frame_set_c    = stop_mid_c && !rx_sync;
   assign parity_set_c   = stop_mid_c && rx_sync && par_pend;
   assign overflow_set_c = push_c && fifo_full && !i_ready;

   // Receive FSM; the oversample counter wraps freely so each mid-bit sample is 16 ticks after the last.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         os_cnt   <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_pend <= 1'b0;
      end else begin
         if (tick) begin
            os_cnt <= (os_cnt == OS_LAST) ? 4'd0 : os_cnt + 4'd1;
         end
         case (state)
            ST_IDLE: begin
               if (tick && !rx_sync) begin
                  os_cnt <= '0;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               if (mid_c) begin
                  if (rx_sync) begin
                     state <= ST_IDLE;
                  end else begin
                     bit_cnt  <= '0;
                     par_pend <= 1'b0;
                     state    <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (mid_c) begin
                  shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (mid_c) begin
                  par_pend <= parity_bad(^shift, rx_sync, PARITY);
                  state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (mid_c) begin
                  state <= rx_sync ? ST_IDLE : ST_BREAK;
               end
            end
            ST_BREAK: begin
               if (tick && rx_sync) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         o_frame_err  <= frame_set_c    | (o_frame_err  & ~i_clear_err);
         o_parity_err <= parity_set_c   | (o_parity_err & ~i_clear_err);
         o_overflow   <= overflow_set_c | (o_overflow   & ~i_clear_err);
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (push_c),
      .din   (shift),
      .pop   (i_ready),
      .head  (o_data),
      .count (o_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, one clock per tick.

module tb_uart_rx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rx_n, rx_e;
   logic       rdy_n, rdy_e;
   logic       clr_n, clr_e;
   logic [7:0] data_n, data_e;
   logic       val_n, val_e;
   logic [2:0] cnt_n, cnt_e;
   logic       fe_n, pe_n, ov_n;
   logic       fe_e, pe_e, ov_e;

   int         compared   = 0;
   int         mismatched = 0;
   logic [7:0] sb_n[$];
   logic [7:0] sb_e[$];
   logic       v_pre, v_post;

   uart_rx_fifo #(
      .BAUD_ACC_WIDTH (4), .BAUD_ACC_INCR (16), .DATA_BITS (8), .PARITY (0), .FIFO_DEPTH (4)
   ) u_dut_n (
      .i_clk (clk), .i_rst (rst), .i_rx (rx_n), .o_data (data_n), .o_valid (val_n),
      .i_ready (rdy_n), .o_count (cnt_n), .o_frame_err (fe_n), .o_parity_err (pe_n),
      .o_overflow (ov_n), .i_clear_err (clr_n)
   );

   uart_rx_fifo #(
      .BAUD_ACC_WIDTH (4), .BAUD_ACC_INCR (16), .DATA_BITS (8), .PARITY (1), .FIFO_DEPTH (4)
   ) u_dut_e (
      .i_clk (clk), .i_rst (rst), .i_rx (rx_e), .o_data (data_e), .o_valid (val_e),
      .i_ready (rdy_e), .o_count (cnt_e), .o_frame_err (fe_e), .o_parity_err (pe_e),
      .o_overflow (ov_e), .i_clear_err (clr_e)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_line(input bit e, input logic b);
      if (e) rx_e = b;
      else   rx_n = b;
   endtask

   task automatic idle(input bit e, input int clocks);
      set_line(e, 1'b1);
      repeat (clocks) @(negedge clk);
   endtask

   // Drives one frame, 16 clocks per bit; optionally pulses rdy_n on clock index ready_at.
   task automatic send(input bit e, input logic [7:0] d, input bit has_par, input bit par,
                       input bit stop, input int ready_at);
      logic [10:0] bits;
      logic [7:0]  exp;
      int          n;
      bits    = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (has_par) begin
         bits[9]  = par;
         bits[10] = stop;
         n = 11;
      end else begin
         bits[9] = stop;
         n = 10;
      end
      for (int k = 0; k < n * 16; k++) begin
         if (k % 16 == 0) set_line(e, bits[k / 16]);
         if (k == 154) v_pre  = val_n;
         if (k == 155) v_post = val_n;
         if (ready_at >= 0 && k == ready_at) begin
            exp = sb_n.pop_front();
            check("full_pop_head", 32'(data_n), 32'(exp));
            rdy_n = 1'b1;
         end
         if (ready_at >= 0 && k == ready_at + 1) rdy_n = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pop(input bit e, input string tag);
      logic [7:0] exp;
      if (e) begin
         exp = sb_e.pop_front();
         check({tag, "_valid"}, 32'(val_e), 32'd1);
         check({tag, "_data"}, 32'(data_e), 32'(exp));
         rdy_e = 1'b1;
         @(negedge clk);
         rdy_e = 1'b0;
      end else begin
         exp = sb_n.pop_front();
         check({tag, "_valid"}, 32'(val_n), 32'd1);
         check({tag, "_data"}, 32'(data_n), 32'(exp));
         rdy_n = 1'b1;
         @(negedge clk);
         rdy_n = 1'b0;
      end
   endtask

   task automatic pulse_clear(input bit e);
      if (e) clr_e = 1'b1;
      else   clr_n = 1'b1;
      @(negedge clk);
      clr_e = 1'b0;
      clr_n = 1'b0;
   endtask

   task automatic check_reset_n(input string tag);
      check({tag, "_valid"}, 32'(val_n), 32'd0);
      check({tag, "_count"}, 32'(cnt_n), 32'd0);
      check({tag, "_data"},  32'(data_n), 32'd0);
      check({tag, "_flags"}, 32'({fe_n, pe_n, ov_n}), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rx_n = 1'b1; rx_e = 1'b1;
      rdy_n = 1'b0; rdy_e = 1'b0; clr_n = 1'b0; clr_e = 1'b0;
      v_pre = 1'b0; v_post = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_n("reset");
      check("reset_e_count", 32'(cnt_e), 32'd0);
      rst = 1'b0;
      idle(0, 20);

      // Basic 8N1 frame with exact push latency
      send(0, 8'hA5, 0, 0, 1, -1);
      sb_n.push_back(8'hA5);
      check("basic_valid_before", 32'(v_pre), 32'd0);
      check("basic_valid_after", 32'(v_post), 32'd1);
      check("basic_count", 32'(cnt_n), 32'd1);
      check("basic_flags", 32'({fe_n, pe_n, ov_n}), 32'd0);
      idle(0, 8);
      pop(0, "basic_pop");
      check("basic_empty_valid", 32'(val_n), 32'd0);
      check("basic_empty_count", 32'(cnt_n), 32'd0);

      // Even parity: good then bad
      idle(1, 16);
      send(1, 8'h03, 1, 0, 1, -1);
      sb_e.push_back(8'h03);
      check("par_good_count", 32'(cnt_e), 32'd1);
      check("par_good_err", 32'(pe_e), 32'd0);
      idle(1, 32);
      send(1, 8'h03, 1, 1, 1, -1);
      check("par_bad_err", 32'(pe_e), 32'd1);
      check("par_bad_count", 32'(cnt_e), 32'd1);
      check("par_bad_frame", 32'(fe_e), 32'd0);
      pulse_clear(1);
      check("par_cleared", 32'(pe_e), 32'd0);
      pop(1, "par_pop");

      // Framing error followed by a long break
      idle(0, 32);
      send(0, 8'h55, 0, 0, 0, -1);
      check("frame_err_set", 32'(fe_n), 32'd1);
      check("frame_no_push", 32'(cnt_n), 32'd0);
      pulse_clear(0);
      repeat (640) @(negedge clk);
      check("break_no_retrigger", 32'(fe_n), 32'd0);
      check("break_count", 32'(cnt_n), 32'd0);
      idle(0, 32);
      send(0, 8'h12, 0, 0, 1, -1);
      sb_n.push_back(8'h12);
      check("after_break_count", 32'(cnt_n), 32'd1);
      idle(0, 8);
      pop(0, "after_break_pop");

      // Four-clock glitch is rejected as a false start
      rx_n = 1'b0;
      repeat (4) @(negedge clk);
      idle(0, 48);
      check("glitch_count", 32'(cnt_n), 32'd0);
      check("glitch_flags", 32'({fe_n, pe_n, ov_n}), 32'd0);

      // Overflow: fifth byte dropped
      for (int b = 1; b <= 5; b++) begin
         send(0, 8'(b), 0, 0, 1, -1);
         if (b <= 4) sb_n.push_back(8'(b));
         idle(0, 8);
      end
      check("ovf_count", 32'(cnt_n), 32'd4);
      check("ovf_flag", 32'(ov_n), 32'd1);
      for (int i = 0; i < 4; i++) pop(0, "ovf_pop");
      check("ovf_drained", 32'(cnt_n), 32'd0);
      pulse_clear(0);
      check("ovf_cleared", 32'(ov_n), 32'd0);

      // Full FIFO with a pop on the exact push cycle
      for (int b = 0; b < 4; b++) begin
         send(0, 8'h21 + 8'(b), 0, 0, 1, -1);
         sb_n.push_back(8'h21 + 8'(b));
         idle(0, 8);
      end
      check("full_count", 32'(cnt_n), 32'd4);
      send(0, 8'h66, 0, 0, 1, 154);
      sb_n.push_back(8'h66);
      check("full_pop_no_ovf", 32'(ov_n), 32'd0);
      check("full_pop_count", 32'(cnt_n), 32'd4);
      idle(0, 8);
      for (int i = 0; i < 4; i++) pop(0, "full_pop_drain");

      // Reset mid-frame with a queued byte and a sticky flag
      send(0, 8'h00, 0, 0, 0, -1);
      idle(0, 32);
      send(0, 8'h77, 0, 0, 1, -1);
      idle(0, 8);
      check("pre_rst_count", 32'(cnt_n), 32'd1);
      check("pre_rst_flag", 32'(fe_n), 32'd1);
      rx_n = 1'b0;
      repeat (16) @(negedge clk);
      rx_n = 1'b1;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_n.delete();
      check_reset_n("midframe_rst");
      idle(0, 32);
      send(0, 8'h3C, 0, 0, 1, -1);
      sb_n.push_back(8'h3C);
      check("post_rst_count", 32'(cnt_n), 32'd1);
      idle(0, 8);
      pop(0, "post_rst_pop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
